// File: rtl/serial_add_pkg.sv
// Shared types and constants for the serial add/subtract controller.
// Optional feature macro: SERIAL_ADD_OVF_EN (adds the rsp_ovf port).
package serial_add_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_SLICE = 3;

   // Number of slices needed to cover n bits with d bits per slice.
   function automatic int ceil_div(input int n, input int d);
      return (n + d - 1) / d;
   endfunction

endpackage

// File: rtl/slice_adder.sv
// Purely combinational SLICE-bit ripple adder with carry in and carry out.
// With SERIAL_ADD_OVF_EN defined, the per-bit carry chain is also exported
// so the controller can derive signed overflow at the operand MSB.
module slice_adder #(
   parameter int SLICE = 3
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADD_OVF_EN
   output logic [SLICE:0]   carry,
`endif
   output logic [SLICE-1:0] sum,
   output logic             cout
);

   logic [SLICE:0] chain;

   // Ripple the carry bit by bit; chain[i] is the carry into bit i.
   always_comb begin : ripple
      logic c;
      // NOTE: every variable written here is given a value before any branch
      // or loop, so no path leaves it unassigned and no latch is inferred.
      c        = cin;
      chain    = '0;
      sum      = '0;
      chain[0] = cin;
      for (int i = 0; i < SLICE; i++) begin
         sum[i]       = a[i] ^ b[i] ^ c;
         c            = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
         chain[i + 1] = c;
      end
   end

   assign cout = chain[SLICE];

`ifdef SERIAL_ADD_OVF_EN
   assign carry = chain;
`endif

endmodule

// File: rtl/serial_add_ctrl.sv
// Multi-cycle WIDTH-bit add/subtract built around one SLICE-bit adder slice,
// processed least-significant slice first with a registered carry.
// Request/response handshake; result held until the consumer takes it.
// Optional feature macro: SERIAL_ADD_OVF_EN (adds rsp_ovf, signed overflow).
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SLICE = DEF_SLICE
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic             req_sub,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_sum,
   output logic             rsp_cout,
   output logic             busy
`ifdef SERIAL_ADD_OVF_EN
  ,output logic             rsp_ovf
`endif
);

   localparam int NSLICE = ceil_div(WIDTH, SLICE);
   localparam int PW     = NSLICE * SLICE;   // padded operand width
   localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

   state_t            state_q, state_d;
   logic              accept, advance, retire;
   logic              last_slice;
   logic [KW-1:0]     k_q;
   logic              carry_q;
   logic [PW-1:0]     a_q, b_q, sum_q;
   logic [WIDTH-1:0]  b_eff;
   logic [SLICE-1:0]  a_slice, b_slice, s_slice;
   logic              s_cout;

   assign last_slice = (k_q == K_LAST);
   assign b_eff      = req_sub ? ~req_b : req_b;
   assign a_slice    = a_q[k_q * SLICE +: SLICE];
   assign b_slice    = b_q[k_q * SLICE +: SLICE];

`ifdef SERIAL_ADD_OVF_EN
   localparam logic [KW-1:0] K_MSB = KW'((WIDTH - 1) / SLICE);
   localparam int            P_MSB = (WIDTH - 1) % SLICE;
   logic [SLICE:0] s_carry;
   logic           ovf_q;
`endif

   slice_adder #(.SLICE(SLICE)) u_slice (
      .a     (a_slice),
      .b     (b_slice),
      .cin   (carry_q),
`ifdef SERIAL_ADD_OVF_EN
      .carry (s_carry),
`endif
      .sum   (s_slice),
      .cout  (s_cout)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of block ordering.
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic and handshake strobes.
   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      busy      = 1'b0;
      accept    = 1'b0;
      advance   = 1'b0;
      retire    = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            busy    = 1'b1;
            advance = 1'b1;
            if (last_slice) state_d = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               retire  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Operand capture, one slice per RUN cycle, result clear on hand-off.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: operand and result registers are reset too, so an aborted
      // operation can never leak partial results onto rsp_sum.
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         k_q     <= '0;
      end else if (accept) begin
         // Zero-pad after inversion so pad bits of B' stay 0.
         a_q     <= PW'(req_a);
         b_q     <= PW'(b_eff);
         carry_q <= req_sub;
         k_q     <= '0;
      end else if (advance) begin
         sum_q[k_q * SLICE +: SLICE] <= s_slice;
         carry_q                     <= s_cout;
         k_q                         <= last_slice ? '0 : k_q + 1'b1;
      end else if (retire) begin
         sum_q   <= '0;
         carry_q <= 1'b0;
      end
   end

   assign rsp_sum = sum_q[WIDTH-1:0];

   // Carry out of bit WIDTH-1: a pad sum bit if padding exists, else the
   // final slice carry.
   generate
      if (PW > WIDTH) begin : g_cout_pad
         assign rsp_cout = sum_q[WIDTH];
      end else begin : g_cout_carry
         assign rsp_cout = carry_q;
      end
   endgenerate

`ifdef SERIAL_ADD_OVF_EN
   // Capture signed overflow while the slice holding the MSB is processed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (advance && (k_q == K_MSB)) begin
         ovf_q <= s_carry[P_MSB] ^ s_carry[P_MSB + 1];
      end else if (accept || retire) begin
         ovf_q <= 1'b0;
      end
   end

   assign rsp_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (default WIDTH=32, SLICE=3).
// Honors SERIAL_ADD_OVF_EN to also check rsp_ovf.
module tb_serial_add_ctrl;

   localparam int WIDTH = 32;
   localparam int SLICE = 3;
   localparam int LAT   = (WIDTH + SLICE - 1) / SLICE;   // edges from accept to rsp_valid

   logic             clk;
   logic             rst_n;
   logic             req_valid;
   logic             req_ready;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic             req_sub;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_sum;
   logic             rsp_cout;
   logic             busy;
`ifdef SERIAL_ADD_OVF_EN
   logic             rsp_ovf;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   serial_add_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_sub   (req_sub),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_sum   (rsp_sum),
      .rsp_cout  (rsp_cout),
      .busy      (busy)
`ifdef SERIAL_ADD_OVF_EN
     ,.rsp_ovf   (rsp_ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operands.
   task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub,
                        output logic [WIDTH-1:0] sum, output logic cout, output logic ovf);
      longint sa, sb, r, maxv, minv;
      sum  = sub ? (a - b) : (a + b);
      cout = sub ? (a >= b) : (((longint'(a) + longint'(b)) >> WIDTH) != 0);
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      r    = sub ? (sa - sb) : (sa + sb);
      maxv = (longint'(1) <<< (WIDTH - 1)) - 1;
      minv = -(longint'(1) <<< (WIDTH - 1));
      ovf  = (r > maxv) || (r < minv);
   endtask

   task automatic check_result(input string tag, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic sub);
      logic [WIDTH-1:0] e_sum;
      logic             e_cout, e_ovf;
      model(a, b, sub, e_sum, e_cout, e_ovf);
      check({tag, "_sum"},  rsp_sum,  e_sum);
      check({tag, "_cout"}, rsp_cout, e_cout);
`ifdef SERIAL_ADD_OVF_EN
      check({tag, "_ovf"},  rsp_ovf,  e_ovf);
`endif
   endtask

   // Accept one request and wait (bounded) for rsp_valid; returns edges waited.
   task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub,
                        input logic early_ready, input logic keep_valid, output int lat);
      @(negedge clk);
      check("pre_req_ready", req_ready, 1'b1);
      req_valid = 1'b1;
      req_a     = a;
      req_b     = b;
      req_sub   = sub;
      rsp_ready = early_ready;
      @(posedge clk); #1;
      req_valid = keep_valid;
      req_a     = $urandom;
      req_b     = $urandom;
      req_sub   = 1'($urandom);
      check("run_busy", busy, 1'b1);
      check("run_req_ready", req_ready, 1'b0);
      lat = 0;
      while (!rsp_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check("latency", lat, LAT);
   endtask

   task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic sub, input logic early_ready, input int hold);
      int lat;
      issue(a, b, sub, early_ready, 1'b0, lat);
      check_result(tag, a, b, sub);
      if (early_ready) begin
         @(posedge clk); #1;
         rsp_ready = 1'b0;
      end else begin
         repeat (hold) begin
            @(posedge clk); #1;
         end
         if (hold > 0) check_result({tag, "_held"}, a, b, sub);
         @(negedge clk);
         rsp_ready = 1'b1;
         @(posedge clk); #1;
         rsp_ready = 1'b0;
      end
      check("post_rsp_valid", rsp_valid, 1'b0);
      check("post_req_ready", req_ready, 1'b1);
      check("post_sum_zero",  rsp_sum,   '0);
      check("post_cout_zero", rsp_cout,  1'b0);
   endtask

   initial begin : stim
      logic [WIDTH-1:0] held_sum, ra, rb;
      logic             held_cout;
      logic             seen;
      int               lat;

      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_a     = '0;
      req_b     = '0;
      req_sub   = 1'b0;
      rsp_ready = 1'b0;
      #12;
      check("rst_req_ready", req_ready, 1'b1);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_busy",      busy,      1'b0);
      check("rst_sum",       rsp_sum,   '0);
      check("rst_cout",      rsp_cout,  1'b0);
`ifdef SERIAL_ADD_OVF_EN
      check("rst_ovf",       rsp_ovf,   1'b0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      // Directed cases.
      run_op("add_5_7",   32'd5,          32'd7,          1'b0, 1'b0, 2);
      run_op("carry_all", 32'hFFFF_FFFF,  32'h0000_0001,  1'b0, 1'b0, 0);
      run_op("sub_3_5",   32'd3,          32'd5,          1'b1, 1'b0, 1);
      run_op("ovf_sub",   32'h8000_0000,  32'h0000_0001,  1'b1, 1'b0, 0);
      run_op("early_rdy", 32'h7FFF_FFFF,  32'h0000_0001,  1'b0, 1'b1, 0);

      // Randomized operations with a bias toward edge operands.
      for (int i = 0; i < 16; i++) begin
         case ($urandom_range(0, 4))
            0:       ra = 32'hFFFF_FFFF;
            1:       ra = 32'h8000_0000;
            2:       ra = 32'h7FFF_FFFF;
            default: ra = $urandom;
         endcase
         rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : 32'($urandom);
         run_op("rand", ra, rb, 1'($urandom), ($urandom_range(0, 3) == 0),
                int'($urandom_range(0, 3)));
      end

      // Backpressure: result held, inputs churning, req_valid high.
      issue(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b0, 1'b1, lat);
      check_result("bp", 32'h1234_5678, 32'h0FED_CBA9, 1'b0);
      held_sum  = 32'h1234_5678 + 32'h0FED_CBA9;
      held_cout = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         req_a   = $urandom;
         req_b   = $urandom;
         req_sub = 1'($urandom);
         @(posedge clk); #1;
         check("bp_sum",       rsp_sum,   held_sum);
         check("bp_cout",      rsp_cout,  held_cout);
         check("bp_req_ready", req_ready, 1'b0);
         check("bp_rsp_valid", rsp_valid, 1'b1);
      end
      @(negedge clk);
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check("bp_release_ready", req_ready, 1'b1);
      check("bp_release_valid", rsp_valid, 1'b0);

      // Reset mid-operation at slice index 4.
      @(negedge clk);
      req_valid = 1'b1;
      req_a     = 32'hDEAD_BEEF;
      req_b     = 32'h1357_9BDF;
      req_sub   = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      check("abort_busy_before", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check("abort_req_ready", req_ready, 1'b1);
      check("abort_busy",      busy,      1'b0);
      check("abort_rsp_valid", rsp_valid, 1'b0);
      check("abort_sum",       rsp_sum,   '0);
      check("abort_cout",      rsp_cout,  1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (20) begin
         @(posedge clk); #1;
         if (rsp_valid) seen = 1'b1;
      end
      check("abort_no_rsp", seen, 1'b0);
      run_op("after_abort", 32'd1, 32'd1, 1'b0, 1'b0, 0);
      check("after_abort_lit", 32'd1 + 32'd1, 32'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Multi-cycle controller that performs a WIDTH-bit add or subtract by repeatedly driving one narrow SLICE-bit ripple-adder slice, least-significant slice first, with a registered carry between passes. It sits between the execute stage and a request/response handshake. It trades area for latency: one small adder slice replaces a full-width ripple adder. Operands are captured on acceptance, and the result is held until the consumer takes it.

## Interface
- WIDTH, 32, operand/result width in bits
- SLICE, 3, bits processed per cycle; NSLICE = ceil(WIDTH/SLICE) is a derived localparam
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request (high only in IDLE)
- req_a  input  WIDTH  operand A
- req_b  input  WIDTH  operand B
- req_sub  input  1  0 = A+B, 1 = A−B
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer takes the result
- rsp_sum  output  WIDTH  result
- rsp_cout  output  1  carry out of bit WIDTH−1 (for subtract, 1 = no borrow)
- busy  output  1  high in RUN or DONE
- rsp_ovf  output  1  signed overflow; present only with SERIAL_ADD_OVF_EN

## Operation
- Reset value of every output: 0, except req_ready = 1. State is IDLE, the slice index is 0 and the carry register is 0.
- States and transitions:
  - IDLE: on req_valid && req_ready, go to RUN.
  - RUN: go to DONE at the edge that processes slice NSLICE−1.
  - DONE: on rsp_ready, go to IDLE.
- Capture on accept:
  - Latch A and B' = req_sub ? ~req_b : req_b.
  - Load the carry register with req_sub.
  - Zero-pad both operands to NSLICE*SLICE bits.
- RUN, slice k:
  - Add A[k*SLICE +: SLICE] + B'[k*SLICE +: SLICE] + carry.
  - Write the SLICE sum bits into the result register.
  - Store the slice carry-out.
  - Increment k.
- rsp_cout is the padded-sum bit at position WIDTH. With zero padding this equals the carry out of bit WIDTH−1. Bits above WIDTH are discarded.
- Inputs req_a, req_b and req_sub are ignored outside the accepting edge.
- rsp_sum, rsp_cout and rsp_ovf are stable while rsp_valid is high, and return to 0 at the DONE→IDLE edge.
- All arithmetic is unsigned modulo 2^WIDTH.

## Timing
- Accept edge E0: the block moves to RUN with k = 0.
- Slice k is committed at edge E0+k+1.
- rsp_valid rises after edge E0+NSLICE. For the defaults this is 11 cycles.
- DONE with rsp_ready high at an edge moves the block to IDLE, and req_ready rises after that edge. There is no same-cycle overlap, so minimum request spacing is NSLICE+2 cycles.
- rsp_ready high before rsp_valid is ignored.
- If rsp_ready stays low, DONE holds indefinitely and req_ready stays 0.
- rst_n asserted in any state aborts immediately:
  - All registers return to reset values.
  - No response is produced for the aborted request.
- WIDTH not a multiple of SLICE: the last slice computes padded bits, which are discarded.

## Configuration
- SERIAL_ADD_OVF_EN defined:
  - Port rsp_ovf exists.
  - rsp_ovf = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1, captured when the slice containing bit WIDTH−1 is processed.
  - rsp_ovf is valid with rsp_valid.
- Not defined: the port, its register and its logic are absent. All other behaviour is identical.

## Structure
- Package serial_add_pkg holds:
  - the state typedef (IDLE, RUN, DONE);
  - the default WIDTH/SLICE constants;
  - the ceil-divide function used to compute NSLICE.
- Sub-module slice_adder is the one natural split:
  - purely combinational SLICE-bit ripple add with carry-in/out;
  - instantiated once inside serial_add_ctrl.
- The controller holds the state register, slice index, carry register, operand and result registers, and the handshake logic.

## Test plan
- Add, 5 + 7, req_sub = 0: rsp_valid rises 11 cycles after accept with rsp_sum = 0x0000000C and rsp_cout = 0.
- Carry chain through every slice, 0xFFFFFFFF + 0x00000001: rsp_sum = 0 and rsp_cout = 1. With the macro, rsp_ovf = 0.
- Subtract with borrow, 3 − 5: rsp_sum = 0xFFFFFFFE and rsp_cout = 0.
- Signed overflow, 0x80000000 − 1: rsp_sum = 0x7FFFFFFF and rsp_cout = 1. With the macro, rsp_ovf = 1.
- Backpressure: hold rsp_ready = 0 for 20 cycles after rsp_valid, while changing req_a and req_b and holding req_valid high.
  - Required: the result stays unchanged, req_ready stays 0 and no second accept occurs.
  - After rsp_ready is pulsed: req_ready is back to 1 the next cycle.
- Reset mid-operation: pulse rst_n low at k = 4. Outputs go to reset values asynchronously, and rsp_valid never rises for the aborted op. The next request 1 + 1 then returns 2.
